// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiplier arbiter slice.
package mult_pkg;

    localparam int MULT_N = 4;
    localparam int ARB_R  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAIL
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int R  = 4,
    parameter int IW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          found
);

    int j;

    // Scan R positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < R; k++) begin
            j = (int'(ptr) + k) % R;
            if (!found && req[j]) begin
                found = 1'b1;
                grant = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin sequencer sharing one sequential multiplier among R requesters.
module mult_rr_arbiter
    import mult_pkg::*;
#(
    parameter int N       = MULT_N,
    parameter int R       = ARB_R,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] a_in,
    input  logic [R*N-1:0] b_in,
    output logic [R-1:0]   ack,
    output logic [2*N-1:0] result_out,
    output logic [R-1:0]   err,
    output logic           busy,
    output logic [N-1:0]   m_A,
    output logic [N-1:0]   m_B,
    output logic           m_data_ready,
    input  logic           m_result_ready,
    input  logic [2*N-1:0] m_result
);

    localparam int IW = idx_w(R);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state, state_nx;
    logic [IW-1:0] ptr, idx, pick;
    logic          found;
    logic [CW-1:0] cnt;

    rr_pick #(.R(R), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick),
        .found (found)
    );

    // Next-state decode; a result in WAIT beats the timeout in the same cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (m_result_ready)               state_nx = DONE;
                else if (cnt == CW'(TIMEOUT - 1)) state_nx = FAIL;
            end
            DONE:    state_nx = IDLE;
            FAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Grant latch, timeout counter, product capture and pointer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            ptr        <= '0;
            m_A        <= '0;
            m_B        <= '0;
            result_out <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        idx <= pick;
                        m_A <= a_in[pick*N +: N];
                        m_B <= b_in[pick*N +: N];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (m_result_ready)               result_out <= m_result;
                    else if (cnt != CW'(TIMEOUT - 1)) cnt <= cnt + 1'b1;
                end
                DONE, FAIL: ptr <= (idx == IW'(R - 1)) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; the owning index selects the ack/err bit.
    always_comb begin
        ack          = '0;
        err          = '0;
        busy         = (state != IDLE);
        m_data_ready = (state == ISSUE) || (state == WAIT);
        if (state == DONE) ack[idx] = 1'b1;
        if (state == FAIL) err[idx] = 1'b1;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one sequential `multiplier` instance among R requesters. It accepts operand pairs from requesters and issues them to the multiplier one at a time with the `data_ready`/`result_ready` handshake. It returns each `2N`-bit product to the requester that owns it. It sits between the requesting units and the single multiplier datapath, so no requester drives the multiplier directly.

## Interface
- `N`, default 4: operand width; must match the multiplier's `N`.
- `R`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum number of cycles to wait for `m_result_ready`; must be greater than the multiplier's worst-case latency.
- `clk` input, 1 bit: single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `req` input, R bits: one request line per requester. A requester holds its line high, with stable operands, until its `ack`.
- `a_in` input, R*N bits: operand A for each requester; requester i uses bits [i*N +: N].
- `b_in` input, R*N bits: operand B for each requester, packed the same way.
- `ack` output, R bits: one-hot, one-cycle pulse when requester i's result is on `result_out`.
- `result_out` output, 2N bits: product; valid only in the cycle `ack` is non-zero.
- `err` output, R bits: one-hot, one-cycle pulse when requester i's job timed out. No `ack` follows for that job.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `m_A` output, N bits: multiplier operand A.
- `m_B` output, N bits: multiplier operand B.
- `m_data_ready` output, 1 bit: multiplier start/hold signal.
- `m_result_ready` input, 1 bit: multiplier completion.
- `m_result` input, 2N bits: multiplier product.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, FAIL.
- **IDLE**
  - If `req` is zero, stay in IDLE.
  - Otherwise grant the first set bit searching upward from `ptr`, wrapping modulo R.
  - Latch the grant index, plus `a_in`/`b_in` of the granted requester, into `m_A`/`m_B`. Go to ISSUE.
- **ISSUE**: assert `m_data_ready`, clear the timeout counter, go to WAIT.
- **WAIT**
  - Keep `m_data_ready` high.
  - If `m_result_ready` is 1, latch `m_result` and go to DONE.
  - Otherwise, if the counter equals TIMEOUT-1, go to FAIL.
  - Otherwise increment the counter.
- **DONE**
  - Drop `m_data_ready` to 0.
  - Drive `ack[idx]` = 1 and `result_out` = the latched product.
  - Set `ptr` = (idx+1) mod R. Go to IDLE.
- **FAIL**
  - Drop `m_data_ready` to 0 and drive `err[idx]` = 1.
  - Set `ptr` = (idx+1) mod R. Go to IDLE.
- `m_A`/`m_B` hold the latched operands from grant until the next grant. Requester operand changes after grant are ignored.
- A `req` still high in the cycle after its `ack` counts as a new request. The rotating `ptr` means that requester waits behind any other pending requesters.
- Products are unsigned, N×N → 2N, taken unmodified from the multiplier. The arbiter performs no arithmetic.
- `result_out` holds its last value between acks. Consumers sample it only when `ack` is high.

## Timing
- Reset values: state=IDLE, `ptr`=0, `ack`=0, `err`=0, `busy`=0, `m_data_ready`=0, `m_A`=0, `m_B`=0, `result_out`=0, counter=0.
- With `req` sampled at edge k:
  - ISSUE during cycle k+1.
  - `m_data_ready` high from cycle k+1 until the edge after `m_result_ready` is sampled high.
- With `m_result_ready` sampled at edge w: `ack` is high in cycle w+1 and the FSM is in IDLE at edge w+2.
- Arbiter overhead is 3 cycles per job on top of the multiplier latency: grant, issue, deliver.
- `m_data_ready` is low for at least one full cycle (DONE, FAIL or IDLE) between consecutive jobs, so the multiplier sees a fresh start.
- Simultaneous requests are resolved purely by `ptr`; there is no fixed priority.
- `reset` mid-job: at the next edge the FSM returns to IDLE and all outputs go to their reset values. The aborted job produces no `ack`/`err`. The requester keeps `req` high and is regranted.
- `m_result_ready` arriving while not in WAIT is ignored.

## Structure
- Shared package `mult_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE, ISSUE, WAIT, DONE, FAIL);
  - the default width constants `MULT_N`=4 and `ARB_R`=4.
- One sub-module, `rr_pick`:
  - combinational, inputs `req` and `ptr`;
  - outputs the granted index and a found flag.
- The top level `mult_rr_arbiter_top` instantiates the arbiter and `multiplier`, which share `clk`. Reset polarity adaptation for `multiplier` is done at that top level.

## Test plan
- **Single request:** req=0001, A0=3, B0=13 → `ack`=0001 for one cycle with `result_out`=39. `m_data_ready` is high from ISSUE until the cycle after `m_result_ready`.
- **All four requesting at once:** (3,13), (15,15), (0,9), (7,2) → acks in order 0,1,2,3 with results 39, 225, 0, 14. `m_data_ready` is low for at least one cycle between jobs.
- **Fairness:** requester 2 holds `req` continuously while requester 0 requests after the first ack → grants alternate 2,0,2. Requester 2 is never granted twice in a row while 0 is pending.
- **Timeout:** with the multiplier model stubbed to never raise `m_result_ready`, and req=0100 → `err`=0100 exactly TIMEOUT+1 cycles after ISSUE, no `ack`, back to IDLE with `ptr`=3.
- **Reset mid-WAIT:** assert `reset` one cycle → all outputs at reset values on the next edge, no `ack`. The still-held request then completes with the correct product.
- **Operand change after grant:** change A0 from 3 to 9 during WAIT → result is still 39.
